cp0_regfile: RTL and testbench

Coprocessor-0 register file: the consumer side of the exception decoder's `exceptiontype` encoding. It holds Status, Cause, EPC, BadVAddr, Count, Compare, PRId and Config, and services MTC0/MFC0. It applies exception entry and ERET updates on the cycle the decoded type is presented, and generates the timer interrupt. It sits in the memory/writeback boundary of the pipeline and feeds `status_o`, `cause_o` and `epc_o` back to the exception decoder.

---
 rtl/cp0_pkg.sv | 82 ++++++++
 rtl/cp0_regfile_if.sv | 30 +++
 rtl/cp0_timer.sv | 63 ++++++
 rtl/cp0_regfile.sv | 151 +++++++++++++++
 tb/tb_cp0_regfile.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register numbers, exceptiontype codes, ExcCode values,
// Status/Cause field positions and reset values.
package cp0_pkg;

  // CP0 register numbers
  localparam logic [4:0] RegBadVAddr = 5'd8;
  localparam logic [4:0] RegCount    = 5'd9;
  localparam logic [4:0] RegCompare  = 5'd11;
  localparam logic [4:0] RegStatus   = 5'd12;
  localparam logic [4:0] RegCause    = 5'd13;
  localparam logic [4:0] RegEpc      = 5'd14;
  localparam logic [4:0] RegPrid     = 5'd15;
  localparam logic [4:0] RegConfig   = 5'd16;

  // Decoded exceptiontype codes from the exception decoder
  localparam logic [31:0] ExcTypeNone = 32'h0000_0000;
  localparam logic [31:0] ExcTypeInt  = 32'h0000_0001;
  localparam logic [31:0] ExcTypeAdEL = 32'h0000_0004;
  localparam logic [31:0] ExcTypeAdES = 32'h0000_0005;
  localparam logic [31:0] ExcTypeSys  = 32'h0000_0008;
  localparam logic [31:0] ExcTypeBp   = 32'h0000_0009;
  localparam logic [31:0] ExcTypeRI   = 32'h0000_000a;
  localparam logic [31:0] ExcTypeOv   = 32'h0000_000c;
  localparam logic [31:0] ExcTypeEret = 32'h0000_000e;

  typedef enum logic [4:0] {
    ExcCodeInt  = 5'd0,
    ExcCodeAdEL = 5'd4,
    ExcCodeAdES = 5'd5,
    ExcCodeSys  = 5'd8,
    ExcCodeBp   = 5'd9,
    ExcCodeRI   = 5'd10,
    ExcCodeOv   = 5'd12
  } exc_code_e;

  // Status / Cause field positions
  localparam int unsigned StatusIeBit  = 0;
  localparam int unsigned StatusExlBit = 1;
  localparam int unsigned CauseExcLsb  = 2;
  localparam int unsigned CauseExcMsb  = 6;
  localparam int unsigned CauseIpSwLsb = 8;
  localparam int unsigned CauseIpSwMsb = 9;
  localparam int unsigned CauseIpHwLsb = 10;
  localparam int unsigned CauseIpHwMsb = 15;
  localparam int unsigned CauseBdBit   = 31;

  // Software-writable bits: Status IM/EXL/IE, Cause IP[1:0]
  localparam logic [31:0] StatusWrMask = 32'h0000_ff03;
  localparam logic [31:0] CauseWrMask  = 32'h0000_0300;

  localparam logic [31:0] StatusRst   = 32'h0040_0000;
  localparam logic [31:0] CauseRst    = 32'h0000_0000;
  localparam logic [31:0] EpcRst      = 32'h0000_0000;
  localparam logic [31:0] BadVAddrRst = 32'h0000_0000;
  localparam logic [31:0] CountRst    = 32'h0000_0000;
  localparam logic [31:0] CompareRst  = 32'h0000_0000;

  function automatic logic is_exc_entry(logic [31:0] etype);
    case (etype)
      ExcTypeInt, ExcTypeAdEL, ExcTypeAdES, ExcTypeSys,
      ExcTypeBp, ExcTypeRI, ExcTypeOv:              return 1'b1;
      default:                                      return 1'b0;
    endcase
  endfunction

  function automatic logic is_addr_exc(logic [31:0] etype);
    return (etype == ExcTypeAdEL) || (etype == ExcTypeAdES);
  endfunction

  function automatic exc_code_e exc_code_of(logic [31:0] etype);
    case (etype)
      ExcTypeAdEL: return ExcCodeAdEL;
      ExcTypeAdES: return ExcCodeAdES;
      ExcTypeSys:  return ExcCodeSys;
      ExcTypeBp:   return ExcCodeBp;
      ExcTypeRI:   return ExcCodeRI;
      ExcTypeOv:   return ExcCodeOv;
      default:     return ExcCodeInt;
    endcase
  endfunction

endpackage

// File: rtl/cp0_regfile_if.sv
// MTC0/MFC0 port, exception inputs and register-value taps of the CP0 register file.
interface cp0_regfile_if;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr;
  logic [5:0]  int_i;
  logic [31:0] exceptiontype;
  logic [31:0] pc_i;
  logic        in_delayslot_i;
  logic [31:0] badvaddr_i;
  logic [31:0] data_o;
  logic [31:0] status_o;
  logic [31:0] cause_o;
  logic [31:0] epc_o;
  logic [31:0] badvaddr_o;
  logic [31:0] count_o;
  logic [31:0] compare_o;
  logic        timer_int_o;

  modport master (
    output we, waddr, wdata, raddr, int_i, exceptiontype, pc_i, in_delayslot_i, badvaddr_i,
    input  data_o, status_o, cause_o, epc_o, badvaddr_o, count_o, compare_o, timer_int_o
  );

  modport slave (
    input  we, waddr, wdata, raddr, int_i, exceptiontype, pc_i, in_delayslot_i, badvaddr_i,
    output data_o, status_o, cause_o, epc_o, badvaddr_o, count_o, compare_o, timer_int_o
  );
endinterface

// File: rtl/cp0_timer.sv
// Half-rate Count register, Compare register and sticky Count==Compare interrupt.
module cp0_timer
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we_i,
  input  logic        compare_we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        timer_int_o
);

  logic        tick_q, tick_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        tint_q, tint_d;

  always_comb begin
    tick_d    = ~tick_q;
    count_d   = count_q;
    compare_d = compare_q;
    tint_d    = tint_q;

    if (count_we_i) begin
      count_d = wdata_i;
    end else if (tick_q) begin
      count_d = count_q + 32'd1;
    end

    if (compare_we_i) begin
      compare_d = wdata_i;
    end

    if ((count_q == compare_q) && (compare_q != 32'd0)) begin
      tint_d = 1'b1;
    end
    // Writing Compare acknowledges the interrupt, even against a same-cycle match
    if (compare_we_i) begin
      tint_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q    <= 1'b0;
      count_q   <= CountRst;
      compare_q <= CompareRst;
      tint_q    <= 1'b0;
    end else begin
      tick_q    <= tick_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      tint_q    <= tint_d;
    end
  end

  assign count_o     = count_q;
  assign compare_o   = compare_q;
  assign timer_int_o = tint_q;

endmodule

// File: rtl/cp0_regfile.sv
// CP0 register file: MTC0/MFC0, exception entry/ERET updates and timer interrupt.
// Optional Count/Compare timer is built when CP0_TIMER_EN is defined.
module cp0_regfile
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID_VAL   = 32'h0000_4220,
  parameter logic [31:0] CONFIG_VAL = 32'h0000_8000
) (
  input logic          clk,
  input logic          rst,
  cp0_regfile_if.slave cp0_bus
);

`ifdef CP0_TIMER_EN
  localparam bit TimerEn = 1'b1;
`else
  localparam bit TimerEn = 1'b0;
`endif

  logic [31:0] status_q, status_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badvaddr_q, badvaddr_d;
  logic [31:0] count;
  logic [31:0] compare;
  logic        timer_int;

  logic        exc_entry;
  logic        exc_eret;
  logic        exl;
  logic [31:0] exc_epc;

  assign exc_entry = is_exc_entry(cp0_bus.exceptiontype);
  assign exc_eret  = (cp0_bus.exceptiontype == ExcTypeEret);
  assign exl       = status_q[StatusExlBit];
  assign exc_epc   = cp0_bus.in_delayslot_i ? (cp0_bus.pc_i - 32'd4) : cp0_bus.pc_i;

`ifdef CP0_TIMER_EN
  cp0_timer u_timer (
    .clk          (clk),
    .rst          (rst),
    .count_we_i   (cp0_bus.we && (cp0_bus.waddr == RegCount)),
    .compare_we_i (cp0_bus.we && (cp0_bus.waddr == RegCompare)),
    .wdata_i      (cp0_bus.wdata),
    .count_o      (count),
    .compare_o    (compare),
    .timer_int_o  (timer_int)
  );
`else
  assign count     = CountRst;
  assign compare   = CompareRst;
  assign timer_int = 1'b0;
`endif

  // MTC0 is applied first; exception/ERET then overrides the fields it owns
  always_comb begin
    status_d   = status_q;
    cause_d    = cause_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;

    if (cp0_bus.we) begin
      unique case (cp0_bus.waddr)
        RegStatus:   status_d   = (status_q & ~StatusWrMask) | (cp0_bus.wdata & StatusWrMask);
        RegCause:    cause_d    = (cause_q & ~CauseWrMask) | (cp0_bus.wdata & CauseWrMask);
        RegEpc:      epc_d      = cp0_bus.wdata;
        RegBadVAddr: badvaddr_d = cp0_bus.wdata;
        default:     ;
      endcase
    end

    cause_d[CauseIpHwMsb:CauseIpHwLsb] = {cp0_bus.int_i[5] | timer_int, cp0_bus.int_i[4:0]};

    if (exc_entry) begin
      // Nested exceptions keep the original return address and BD
      if (!exl) begin
        epc_d               = exc_epc;
        cause_d[CauseBdBit] = cp0_bus.in_delayslot_i;
      end
      status_d[StatusExlBit]           = 1'b1;
      cause_d[CauseExcMsb:CauseExcLsb] = exc_code_of(cp0_bus.exceptiontype);
      if (is_addr_exc(cp0_bus.exceptiontype)) begin
        badvaddr_d = cp0_bus.badvaddr_i;
      end
    end else if (exc_eret) begin
      status_d[StatusExlBit] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status_q   <= StatusRst;
      cause_q    <= CauseRst;
      epc_q      <= EpcRst;
      badvaddr_q <= BadVAddrRst;
    end else begin
      status_q   <= status_d;
      cause_q    <= cause_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
    end
  end

  // Read views: the register targeted by a same-cycle MTC0 shows its post-write value
  logic [31:0] status_rd, cause_rd, epc_rd, badvaddr_rd, count_rd, compare_rd;

  always_comb begin
    status_rd   = status_q;
    cause_rd    = cause_q;
    epc_rd      = epc_q;
    badvaddr_rd = badvaddr_q;
    count_rd    = count;
    compare_rd  = compare;

    if (cp0_bus.we) begin
      unique case (cp0_bus.waddr)
        RegStatus:   status_rd   = (status_q & ~StatusWrMask) | (cp0_bus.wdata & StatusWrMask);
        RegCause:    cause_rd    = (cause_q & ~CauseWrMask) | (cp0_bus.wdata & CauseWrMask);
        RegEpc:      epc_rd      = cp0_bus.wdata;
        RegBadVAddr: badvaddr_rd = cp0_bus.wdata;
        RegCount:    count_rd    = TimerEn ? cp0_bus.wdata : count;
        RegCompare:  compare_rd  = TimerEn ? cp0_bus.wdata : compare;
        default:     ;
      endcase
    end
  end

  always_comb begin
    cp0_bus.data_o = 32'd0;
    unique case (cp0_bus.raddr)
      RegBadVAddr: cp0_bus.data_o = badvaddr_rd;
      RegCount:    cp0_bus.data_o = count_rd;
      RegCompare:  cp0_bus.data_o = compare_rd;
      RegStatus:   cp0_bus.data_o = status_rd;
      RegCause:    cp0_bus.data_o = cause_rd;
      RegEpc:      cp0_bus.data_o = epc_rd;
      RegPrid:     cp0_bus.data_o = PRID_VAL;
      RegConfig:   cp0_bus.data_o = CONFIG_VAL;
      default:     cp0_bus.data_o = 32'd0;
    endcase
  end

  assign cp0_bus.status_o    = status_q;
  assign cp0_bus.cause_o     = cause_q;
  assign cp0_bus.epc_o       = epc_q;
  assign cp0_bus.badvaddr_o  = badvaddr_q;
  assign cp0_bus.count_o     = count;
  assign cp0_bus.compare_o   = compare;
  assign cp0_bus.timer_int_o = timer_int;

endmodule

// File: tb/tb_cp0_regfile.sv
// Bench for cp0_regfile: field-level reference model checked every cycle plus
// directed vectors with literal expectations.
module tb_cp0_regfile;

  logic clk;
  logic rst;
  logic chk_en;
  int   n_tests;
  int   n_fail;

  cp0_regfile_if bus ();

  cp0_regfile dut (
    .clk     (clk),
    .rst     (rst),
    .cp0_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef CP0_TIMER_EN
  localparam bit TimerOn = 1'b1;
`else
  localparam bit TimerOn = 1'b0;
`endif

  // Architectural state kept as named fields rather than packed registers
  typedef struct packed {
    logic [7:0]  im;
    logic        exl;
    logic        ie;
    logic [1:0]  ip_sw;
    logic [5:0]  ip_hw;
    logic        bd;
    logic [4:0]  exc;
    logic [31:0] epc;
    logic [31:0] badv;
    logic [31:0] count;
    logic [31:0] compare;
    logic        tint;
    logic [31:0] edges;
  } model_t;

  model_t m, nx;

  function automatic logic [31:0] m_status();
    return {9'b0, 1'b1, 6'b0, m.im, 6'b0, m.exl, m.ie};
  endfunction

  function automatic logic [31:0] m_cause();
    return {m.bd, 15'b0, m.ip_hw, m.ip_sw, 1'b0, m.exc, 2'b0};
  endfunction

  always_comb begin
    nx = m;
    nx.edges = m.edges + 32'd1;
    if (bus.we) begin
      case (bus.waddr)
        5'd12: begin
          nx.im  = bus.wdata[15:8];
          nx.exl = bus.wdata[1];
          nx.ie  = bus.wdata[0];
        end
        5'd13: nx.ip_sw = bus.wdata[9:8];
        5'd14: nx.epc   = bus.wdata;
        5'd8:  nx.badv  = bus.wdata;
        default: ;
      endcase
    end
    if (TimerOn) begin
      // Count advances on every second edge after reset (odd edge index)
      if (bus.we && bus.waddr == 5'd9) nx.count = bus.wdata;
      else if (m.edges[0]) nx.count = m.count + 32'd1;
      if (bus.we && bus.waddr == 5'd11) nx.compare = bus.wdata;
      if (m.count == m.compare && m.compare != 32'd0) nx.tint = 1'b1;
      if (bus.we && bus.waddr == 5'd11) nx.tint = 1'b0;
    end
    nx.ip_hw = {bus.int_i[5] | m.tint, bus.int_i[4:0]};
    case (bus.exceptiontype)
      32'h1, 32'h4, 32'h5, 32'h8, 32'h9, 32'ha, 32'hc: begin
        if (!m.exl) begin
          nx.epc = bus.in_delayslot_i ? bus.pc_i - 32'd4 : bus.pc_i;
          nx.bd  = bus.in_delayslot_i;
        end
        nx.exl = 1'b1;
        nx.exc = (bus.exceptiontype == 32'h1) ? 5'd0 : bus.exceptiontype[4:0];
        if (bus.exceptiontype == 32'h4 || bus.exceptiontype == 32'h5) nx.badv = bus.badvaddr_i;
      end
      32'he: nx.exl = 1'b0;
      default: ;
    endcase
    if (rst) nx = '0;
  end

  always @(posedge clk) m <= nx;

  function automatic logic [31:0] exp_rd();
    logic [31:0] st, ca, ep, bv, cn, cm;
    st = m_status();
    ca = m_cause();
    ep = m.epc;
    bv = m.badv;
    cn = m.count;
    cm = m.compare;
    if (bus.we) begin
      case (bus.waddr)
        5'd12: st = {9'b0, 1'b1, 6'b0, bus.wdata[15:8], 6'b0, bus.wdata[1:0]};
        5'd13: ca = {m_cause() & 32'hffff_fcff} | (bus.wdata & 32'h0000_0300);
        5'd14: ep = bus.wdata;
        5'd8:  bv = bus.wdata;
        5'd9:  if (TimerOn) cn = bus.wdata;
        5'd11: if (TimerOn) cm = bus.wdata;
        default: ;
      endcase
    end
    case (bus.raddr)
      5'd8:    return bv;
      5'd9:    return cn;
      5'd11:   return cm;
      5'd12:   return st;
      5'd13:   return ca;
      5'd14:   return ep;
      5'd15:   return 32'h0000_4220;
      5'd16:   return 32'h0000_8000;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("status_o", bus.status_o, m_status());
      chk("cause_o", bus.cause_o, m_cause());
      chk("epc_o", bus.epc_o, m.epc);
      chk("badvaddr_o", bus.badvaddr_o, m.badv);
      chk("count_o", bus.count_o, m.count);
      chk("compare_o", bus.compare_o, m.compare);
      chk("timer_int_o", {31'b0, bus.timer_int_o}, {31'b0, m.tint});
      chk("data_o", bus.data_o, exp_rd());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    bus.we            = 1'b0;
    bus.exceptiontype = 32'h0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus.we    = 1'b1;
    bus.waddr = a;
    bus.wdata = d;
  endtask

  task automatic exc(input logic [31:0] t, input logic [31:0] pc, input logic ds);
    bus.exceptiontype  = t;
    bus.pc_i           = pc;
    bus.in_delayslot_i = ds;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    chk_en  = 1'b0;
    rst     = 1'b1;
    bus.we = 1'b0;  bus.waddr = '0;  bus.wdata = '0;  bus.raddr = '0;
    bus.int_i = '0; bus.exceptiontype = '0; bus.pc_i = '0;
    bus.in_delayslot_i = 1'b0; bus.badvaddr_i = '0;

    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    bus.raddr = 5'd12;
    @(negedge clk);
    chk("rst_status_rd", bus.data_o, 32'h0040_0000);
    chk("rst_epc", bus.epc_o, 32'h0);

    wr(5'd12, 32'hffff_ffff);
    @(negedge clk);
    chk("fwd_status", bus.data_o, 32'h0040_ff03);
    step(); @(negedge clk);
    chk("status_masked", bus.status_o, 32'h0040_ff03);

    wr(5'd12, 32'h0000_0001); step();

    exc(32'h8, 32'hbfc0_0100, 1'b0); step(); @(negedge clk);
    chk("sys_epc", bus.epc_o, 32'hbfc0_0100);
    chk("sys_exccode", bus.cause_o & 32'h7c, 32'h20);
    chk("sys_exl", bus.status_o & 32'h2, 32'h2);

    exc(32'he, 32'h0, 1'b0); step(); @(negedge clk);
    chk("eret_exl", bus.status_o & 32'h2, 32'h0);
    chk("eret_epc", bus.epc_o, 32'hbfc0_0100);

    exc(32'ha, 32'hbfc0_0200, 1'b1); step(); @(negedge clk);
    chk("ri_ds_epc", bus.epc_o, 32'hbfc0_01fc);
    chk("ri_bd", bus.cause_o & 32'h8000_0000, 32'h8000_0000);

    exc(32'hc, 32'hbfc0_0300, 1'b0); step(); @(negedge clk);
    chk("nested_epc", bus.epc_o, 32'hbfc0_01fc);
    chk("nested_exccode", bus.cause_o & 32'h7c, 32'h30);
    chk("nested_bd", bus.cause_o & 32'h8000_0000, 32'h8000_0000);

    exc(32'he, 32'h0, 1'b0); step();
    bus.badvaddr_i = 32'h8000_0003;
    exc(32'h5, 32'hbfc0_0304, 1'b0); step(); @(negedge clk);
    chk("ades_badv", bus.badvaddr_o, 32'h8000_0003);
    chk("ades_exccode", bus.cause_o & 32'h7c, 32'h14);

    exc(32'he, 32'h0, 1'b0); step();
    wr(5'd14, 32'h0000_1234);
    bus.badvaddr_i = 32'h0000_0011;
    exc(32'h4, 32'hbfc0_0400, 1'b0); step(); @(negedge clk);
    chk("mtc0_vs_exc_epc", bus.epc_o, 32'hbfc0_0400);
    chk("adel_exccode", bus.cause_o & 32'h7c, 32'h10);

    exc(32'he, 32'h0, 1'b0); step();
    exc(32'h1, 32'hbfc0_0500, 1'b0); step(); @(negedge clk);
    chk("int_exccode", bus.cause_o & 32'h7c, 32'h0);

    exc(32'he, 32'h0, 1'b0); step();
    exc(32'h3, 32'hbfc0_0600, 1'b0); step(); @(negedge clk);
    chk("unknown_type_exl", bus.status_o & 32'h2, 32'h0);

    bus.int_i = 6'b10_1010; step(); @(negedge clk);
    chk("hw_ip", bus.cause_o & 32'hfc00, 32'ha800);

    bus.int_i = 6'b0;
    wr(5'd13, 32'hffff_ffff); step(); @(negedge clk);
    chk("cause_sw_ip", bus.cause_o & 32'hff00, 32'h0300);

    bus.raddr = 5'd7;  @(negedge clk); chk("rd_unmapped", bus.data_o, 32'h0);
    bus.raddr = 5'd16; @(negedge clk); chk("rd_config", bus.data_o, 32'h0000_8000);
    bus.raddr = 5'd15;
    wr(5'd15, 32'hffff_ffff); @(negedge clk);
    chk("prid_ro", bus.data_o, 32'h0000_4220);
    step();

    bus.raddr = 5'd14;
    wr(5'd14, 32'hcafe_0000); @(negedge clk);
    chk("fwd_epc", bus.data_o, 32'hcafe_0000);
    step();

    // Reset while a write and an exception are both presented
    rst = 1'b1;
    wr(5'd12, 32'hffff_ffff);
    exc(32'h8, 32'hbfc0_0700, 1'b0);
    step(); @(negedge clk);
    chk("midrst_status", bus.status_o, 32'h0040_0000);
    chk("midrst_epc", bus.epc_o, 32'h0);
    chk("midrst_cause", bus.cause_o, 32'h0);

    rst = 1'b0;
    wr(5'd11, 32'h5);
    step();
    for (int i = 0; i < 9; i++) step();
    @(negedge clk);
    if (TimerOn) begin
      chk("timer_count5", bus.count_o, 32'h5);
      chk("timer_not_yet", {31'b0, bus.timer_int_o}, 32'h0);
      step(); @(negedge clk);
      chk("timer_rise", {31'b0, bus.timer_int_o}, 32'h1);
      step(); @(negedge clk);
      chk("timer_cause15", bus.cause_o & 32'h8000, 32'h8000);
      wr(5'd11, 32'h0); step(); @(negedge clk);
      chk("timer_clear", {31'b0, bus.timer_int_o}, 32'h0);
    end else begin
      chk("notimer_count", bus.count_o, 32'h0);
      chk("notimer_compare", bus.compare_o, 32'h0);
      step(); step(); @(negedge clk);
      chk("notimer_int", {31'b0, bus.timer_int_o}, 32'h0);
    end

    wr(5'd9, 32'hffff_fffe); step();
    for (int i = 0; i < 6; i++) step();
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
